// File: rtl/mem_rr_model_if.sv
// Request/response bundle between NUM_CH cache-side requesters and mem_rr_model.
// The master side is the cache channels. The slave side is the memory.
interface mem_rr_model_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 128
);
    localparam int unsigned ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH-1:0]        req_rw;
    logic [NUM_CH*ADDR_W-1:0] req_addr;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        resp_ready;
    logic [DATA_W-1:0]        resp_data;
    logic                     busy;
    logic [ID_W-1:0]          grant_id;

    modport master (
        output req_valid, req_rw, req_addr, req_data,
        input  resp_ready, resp_data, busy, grant_id
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_data,
        output resp_ready, resp_data, busy, grant_id
    );
endinterface

// File: rtl/mem_rr_model.sv
// Multi-channel main memory: round-robin grant, fixed latency, one access in flight.
// Writes commit only at the RESP edge, so a reset mid-access leaves the array untouched.
module mem_rr_model #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input logic          clock,
    input logic          reset,
    mem_rr_model_if.slave bus
);
    localparam int unsigned ID_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                any_valid;
    logic [ID_W-1:0]     sel;
    logic                unused_addr;

    // Upper address bits alias onto the array.
    assign idx         = addr_q[IDX_W-1:0];
    assign unused_addr = ^addr_q;

    // Search starts at rr_ptr and wraps; first valid channel wins.
    always_comb begin
        any_valid = 1'b0;
        sel       = '0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            if (!any_valid && bus.req_valid[(32'(rr_ptr_q) + off) % NUM_CH]) begin
                any_valid = 1'b1;
                sel       = ID_W'((32'(rr_ptr_q) + off) % NUM_CH);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle: begin
                if (any_valid) begin
                    grant_d  = sel;
                    rw_d     = bus.req_rw[sel];
                    addr_d   = bus.req_addr[32'(sel)*ADDR_W +: ADDR_W];
                    data_d   = bus.req_data[32'(sel)*DATA_W +: DATA_W];
                    cnt_d    = CNT_W'(LATENCY - 1);
                    state_d  = (LATENCY == 1) ? StResp : StWait;
                    rr_ptr_d = (sel == ID_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Array has no reset; the commit is suppressed while reset is asserted.
    always_ff @(posedge clock) begin
        if (!reset && state_q == StResp && rw_q) begin
            mem[idx] <= data_q;
        end
    end

    always_comb begin
        bus.resp_ready = '0;
        bus.resp_data  = '0;
        if (state_q == StResp) begin
            bus.resp_ready[grant_q] = 1'b1;
            bus.resp_data           = rw_q ? data_q : mem[idx];
        end
    end

    assign bus.busy     = (state_q != StIdle);
    assign bus.grant_id = grant_q;
endmodule

// File: tb/tb_mem_rr_model.sv
// Directed bench for mem_rr_model: a 2-channel LATENCY=4 instance and a 4-channel LATENCY=1 one.
module tb_mem_rr_model;
    localparam logic [127:0] PAT_A5 = {4{32'hA5A5_A5A5}};

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    mem_rr_model_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(128)) ifa ();
    mem_rr_model_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32))  ifb ();

    mem_rr_model #(.NUM_CH(2), .ADDR_W(32), .DATA_W(128), .DEPTH(1024), .LATENCY(4)) dut_a (
        .clock(clock),
        .reset(reset),
        .bus  (ifa)
    );

    mem_rr_model #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .DEPTH(16), .LATENCY(1)) dut_b (
        .clock(clock),
        .reset(reset),
        .bus  (ifb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic issue_a(input int ch, input logic rw, input logic [31:0] addr,
                           input logic [127:0] data);
        ifa.req_rw[ch]             = rw;
        ifa.req_addr[ch*32 +: 32]  = addr;
        ifa.req_data[ch*128 +: 128] = data;
        ifa.req_valid[ch]          = 1'b1;
    endtask

    // Counts falling edges until a ready pulse; rdy stays 0 if none arrives in budget.
    task automatic wait_ready_a(input bit keep, output logic [1:0] rdy, output int cycles,
                                output logic [127:0] data, output logic gid);
        rdy = '0; cycles = 0; data = '0; gid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            cycles++;
            if (ifa.resp_ready != 2'b00) begin
                rdy  = ifa.resp_ready;
                data = ifa.resp_data;
                gid  = ifa.grant_id;
                if (!keep) ifa.req_valid = ifa.req_valid & ~ifa.resp_ready;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++; if (ifa.resp_ready !== 2'b00) begin errors++;
            $display("FAIL reset_ready got=%b exp=00", ifa.resp_ready); end
        checks++; if (ifa.resp_data !== 128'h0) begin errors++;
            $display("FAIL reset_data got=%h exp=0", ifa.resp_data); end
        checks++; if (ifa.busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy got=%b exp=0", ifa.busy); end
        checks++; if (ifa.grant_id !== 1'b0) begin errors++;
            $display("FAIL reset_grant got=%b exp=0", ifa.grant_id); end
        checks++; if (ifb.resp_ready !== 4'b0000 || ifb.busy !== 1'b0) begin errors++;
            $display("FAIL reset_b got ready=%b busy=%b exp 0000/0", ifb.resp_ready, ifb.busy); end
    endtask

    task automatic test_write_read();
        logic [1:0] rdy; int cyc; logic [127:0] d; logic g;
        issue_a(0, 1'b1, 32'h10, PAT_A5);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b01 || cyc != 4) begin errors++;
            $display("FAIL wr_latency got rdy=%b cyc=%0d exp rdy=01 cyc=4", rdy, cyc); end
        checks++; if (d !== PAT_A5) begin errors++;
            $display("FAIL wr_echo got=%h exp=%h", d, PAT_A5); end
        tick();
        issue_a(0, 1'b0, 32'h10, 128'h0);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b01 || cyc != 4) begin errors++;
            $display("FAIL rd_latency got rdy=%b cyc=%0d exp rdy=01 cyc=4", rdy, cyc); end
        checks++; if (d !== PAT_A5) begin errors++;
            $display("FAIL rd_data got=%h exp=%h", d, PAT_A5); end
    endtask

    task automatic test_round_robin();
        logic [1:0] rdy; int cyc; logic [127:0] d; logic g;
        tick();
        reset = 1'b1;
        issue_a(0, 1'b0, 32'h10, 128'h0);
        issue_a(1, 1'b0, 32'h10, 128'h0);
        tick(); tick();
        checks++; if (ifa.busy !== 1'b0) begin errors++;
            $display("FAIL rr_reset_wins got busy=%b exp=0", ifa.busy); end
        reset = 1'b0;
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b01 || cyc != 4 || g !== 1'b0) begin errors++;
            $display("FAIL rr_first got rdy=%b cyc=%0d gid=%b exp 01/4/0", rdy, cyc, g); end
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b10 || cyc != 5 || g !== 1'b1) begin errors++;
            $display("FAIL rr_second got rdy=%b cyc=%0d gid=%b exp 10/5/1", rdy, cyc, g); end
        // Lone ch0 access moves rr_ptr to 1 before the next pair.
        tick();
        issue_a(0, 1'b0, 32'h10, 128'h0);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b01) begin errors++;
            $display("FAIL rr_lone got rdy=%b exp=01", rdy); end
        tick();
        issue_a(0, 1'b0, 32'h10, 128'h0);
        issue_a(1, 1'b0, 32'h10, 128'h0);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b10 || g !== 1'b1) begin errors++;
            $display("FAIL rr_rot_first got rdy=%b gid=%b exp 10/1", rdy, g); end
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b01 || g !== 1'b0 || d !== PAT_A5) begin errors++;
            $display("FAIL rr_rot_second got rdy=%b gid=%b d=%h exp 01/0/%h", rdy, g, d, PAT_A5); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] rdy; int cyc; logic [127:0] d; logic g;
        tick();
        issue_a(1, 1'b0, 32'h10, 128'h0);
        wait_ready_a(1'b1, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b10 || cyc != 4) begin errors++;
            $display("FAIL b2b_first got rdy=%b cyc=%0d exp 10/4", rdy, cyc); end
        for (int n = 0; n < 2; n++) begin
            wait_ready_a(1'b1, rdy, cyc, d, g);
            checks++; if (rdy !== 2'b10 || cyc != 5 || d !== PAT_A5) begin errors++;
                $display("FAIL b2b_period%0d got rdy=%b cyc=%0d exp 10/5", n, rdy, cyc); end
        end
        ifa.req_valid[1] = 1'b0;
    endtask

    task automatic test_alias();
        logic [1:0] rdy; int cyc; logic [127:0] d; logic g;
        tick();
        issue_a(0, 1'b1, 32'h400, 128'h1234);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        tick();
        issue_a(1, 1'b0, 32'h000, 128'h0);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b10 || d !== 128'h1234) begin errors++;
            $display("FAIL alias got rdy=%b d=%h exp 10/1234", rdy, d); end
    endtask

    task automatic test_reset_abort();
        logic [1:0] rdy; int cyc; logic [127:0] d; logic g; bit seen;
        tick();
        issue_a(0, 1'b1, 32'h20, 128'h0);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        tick();
        issue_a(0, 1'b1, 32'h20, 128'hBEEF);
        tick(); tick();
        reset = 1'b1;
        ifa.req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) reset = 1'b0;
            if (ifa.resp_ready != 2'b00) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL abort_no_ready got pulse=%b exp=0", seen); end
        issue_a(0, 1'b0, 32'h20, 128'h0);
        wait_ready_a(1'b0, rdy, cyc, d, g);
        checks++; if (rdy !== 2'b01 || d !== 128'h0) begin errors++;
            $display("FAIL abort_not_committed got rdy=%b d=%h exp 01/0", rdy, d); end
    endtask

    task automatic test_lat1_four_ch();
        int n;
        int exp_cyc;
        tick();
        for (int c = 0; c < 4; c++) ifb.req_addr[c*32 +: 32] = 32'(c);
        ifb.req_rw    = 4'b0000;
        ifb.req_data  = '0;
        ifb.req_valid = 4'b1111;
        n = 0;
        for (int cyc = 1; cyc <= 20 && n < 4; cyc++) begin
            tick();
            if (ifb.resp_ready != 4'b0000) begin
                exp_cyc = 2 * n + 1;
                checks++;
                if (ifb.resp_ready !== (4'b0001 << n) || cyc != exp_cyc ||
                    ifb.grant_id !== 2'(n)) begin
                    errors++;
                    $display("FAIL lat1_pulse%0d got rdy=%b cyc=%0d gid=%0d exp %b/%0d/%0d",
                             n, ifb.resp_ready, cyc, ifb.grant_id, 4'b0001 << n, exp_cyc, n);
                end
                ifb.req_valid = ifb.req_valid & ~ifb.resp_ready;
                n++;
            end
        end
        checks++; if (n != 4) begin errors++;
            $display("FAIL lat1_count got=%0d exp=4", n); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        ifa.req_valid = '0; ifa.req_rw = '0; ifa.req_addr = '0; ifa.req_data = '0;
        ifb.req_valid = '0; ifb.req_rw = '0; ifb.req_addr = '0; ifb.req_data = '0;
        tick(); tick(); tick();
        test_reset();
        reset = 1'b0;
        tick();
        test_write_read();
        test_round_robin();
        test_back_to_back();
        test_alias();
        test_reset_abort();
        test_lat1_four_ch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
